// File: rtl/mul_err_sweep_ctrl_if.sv
// rtl/mul_err_sweep_ctrl_if.sv - per-pair result stream between sweep controller and logger
interface mul_err_sweep_ctrl_if #(
  parameter int OP_W = 8
);
  logic                     res_valid;
  logic                     res_ready;
  logic signed [OP_W-1:0]   res_a;
  logic signed [OP_W-1:0]   res_b;
  logic signed [2*OP_W-1:0] res_exact;
  logic signed [2*OP_W-1:0] res_approx;

  modport master (
    output res_valid,
    output res_a,
    output res_b,
    output res_exact,
    output res_approx,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_a,
    input  res_b,
    input  res_exact,
    input  res_approx,
    output res_ready
  );
endinterface

// File: rtl/signed_int_mul.sv
// rtl/signed_int_mul.sv - approximate sign-magnitude 8x8 multiplier with maskable partial-product rows
module signed_int_mul (
  input  logic signed [7:0]  A,
  input  logic signed [7:0]  B,
  input  logic        [5:0]  Conf_Bit_Mask,
  output logic signed [15:0] R
);
  logic [7:0]  w_a_mag;
  logic [7:0]  w_b_mag;
  logic [7:0]  w_rows;
  logic        w_neg;
  logic [15:0] w_sum;

  // Magnitudes; -128 maps to 8'h80, which is exactly 128 unsigned.
  assign w_a_mag = A[7] ? -A : A;
  assign w_b_mag = B[7] ? -B : B;
  assign w_neg   = A[7] ^ B[7];

  // Rows 0..5 of the multiplier magnitude are gated by the mask; rows 6..7 always contribute.
  assign w_rows = w_b_mag & {2'b11, Conf_Bit_Mask};

  // Shift-and-add over the enabled partial-product rows.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_rows[i]) begin
        w_sum = w_sum + ({8'b0, w_a_mag} << i);
      end
    end
  end

  assign R = w_neg ? -$signed(w_sum) : $signed(w_sum);
endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// rtl/mul_err_sweep_ctrl.sv - exhaustive (A,B) error-characterisation sweep of signed_int_mul
module mul_err_sweep_ctrl #(
  parameter int OP_W   = 8,
  parameter int MASK_W = 6,
  parameter int SUM_W  = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MASK_W-1:0]      conf_mask,
  output logic                   busy,
  output logic                   done,
  mul_err_sweep_ctrl_if.master   res_if,
  output logic [16:0]            err_count,
  output logic [SUM_W-1:0]       err_sum,
  output logic [2*OP_W:0]        max_err,
  output logic signed [OP_W-1:0] max_err_a,
  output logic signed [OP_W-1:0] max_err_b
);
  localparam int D_W = 2*OP_W + 1;
  localparam logic signed [OP_W-1:0] OP_MIN = {1'b1, {(OP_W-1){1'b0}}};
  localparam logic signed [OP_W-1:0] OP_MAX = {1'b0, {(OP_W-1){1'b1}}};
  localparam logic signed [OP_W-1:0] OP_ONE = OP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [MASK_W-1:0]        r_mask;
  logic signed [OP_W-1:0]   r_a;
  logic signed [OP_W-1:0]   r_b;
  logic                     r_s1_valid;

  logic                     w_start_ok;
  logic                     w_hs;
  logic                     w_s2_free;
  logic                     w_s1_move;
  logic                     w_last;
  logic signed [2*OP_W-1:0] w_exact;
  logic signed [2*OP_W-1:0] w_approx;
  logic signed [D_W-1:0]    w_diff;
  logic [D_W-1:0]           w_abs;
  logic                     w_nz;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs       = res_if.res_valid && res_if.res_ready;
  // The result stage can take a new pair when it is empty or being drained this cycle.
  assign w_s2_free  = !res_if.res_valid || res_if.res_ready;
  assign w_s1_move  = r_s1_valid && w_s2_free;
  assign w_last     = (r_a == OP_MAX) && (r_b == OP_MAX);

  signed_int_mul u_mul (
    .A             (r_a),
    .B             (r_b),
    .Conf_Bit_Mask (r_mask),
    .R             (w_approx)
  );

  assign w_exact = (2*OP_W)'(r_a) * (2*OP_W)'(r_b);

  // Error of the beat currently on the stream, widened by one bit so the difference cannot overflow.
  assign w_diff = {res_if.res_exact[2*OP_W-1], res_if.res_exact}
                - {res_if.res_approx[2*OP_W-1], res_if.res_approx};
  assign w_abs  = w_diff[D_W-1] ? -w_diff : w_diff;
  assign w_nz   = (w_abs != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: RUN ends when (max,max) enters the result stage, DRAIN when it is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:          if (w_s1_move && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (w_hs) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // Stage 1: operand counter; B is the inner loop, and the counter never steps past (max,max).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s1_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_mask     <= conf_mask;
      r_a        <= OP_MIN;
      r_b        <= OP_MIN;
      r_s1_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (!r_s1_valid) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_move) begin
        if (w_last) begin
          r_s1_valid <= 1'b0;
        end else if (r_b == OP_MAX) begin
          r_b <= OP_MIN;
          r_a <= r_a + OP_ONE;
        end else begin
          r_b <= r_b + OP_ONE;
        end
      end
    end
  end

  // Stage 2: result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_if.res_valid  <= 1'b0;
      res_if.res_a      <= '0;
      res_if.res_b      <= '0;
      res_if.res_exact  <= '0;
      res_if.res_approx <= '0;
    end else if (w_s2_free) begin
      res_if.res_valid <= w_s1_move;
      if (w_s1_move) begin
        res_if.res_a      <= r_a;
        res_if.res_b      <= r_b;
        res_if.res_exact  <= w_exact;
        res_if.res_approx <= w_approx;
      end
    end
  end

  // Statistics: cleared on accepted start, updated once per handshake; ties keep the earliest pair.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      err_count <= '0;
      err_sum   <= '0;
      max_err   <= '0;
      max_err_a <= '0;
      max_err_b <= '0;
    end else if (w_hs) begin
      err_count <= err_count + {16'b0, w_nz};
      err_sum   <= err_sum + {{(SUM_W-D_W){1'b0}}, w_abs};
      if (w_abs > max_err) begin
        max_err   <= w_abs;
        max_err_a <= res_if.res_a;
        max_err_b <= res_if.res_b;
      end
    end
  end
endmodule

// File: doc/mul_err_sweep_ctrl.md
Name: mul_err_sweep_ctrl

Overview:
- Hardware characterisation sequencer for the approximate signed multiplier `signed_int_mul`. It has 8-bit signed A/B inputs, a 16-bit signed R output and a 6-bit Conf_Bit_Mask.
- It owns one `signed_int_mul` instance and sweeps every (A,B) pair at a latched accuracy configuration.
- In parallel it computes the exact product and accumulates error statistics: error count, summed absolute error, and max error with its operands.
- Per-pair results stream out on a valid/ready port for logging.

Parameters:
- OP_W, 8, operand width; fixed to match signed_int_mul.
- MASK_W, 6, width of Conf_Bit_Mask.
- SUM_W, 34, width of summed absolute error accumulator.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin sweep; sampled only in IDLE or DONE
- conf_mask  in  MASK_W  accuracy config; latched on accepted start
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE until next accepted start or rst
- res_valid  out  1  result beat valid
- res_ready  in  1  consumer accepts beat
- res_a  out  OP_W  signed operand A of beat
- res_b  out  OP_W  signed operand B of beat
- res_exact  out  2*OP_W  signed exact A*B
- res_approx  out  2*OP_W  signed R from signed_int_mul
- err_count  out  17  pairs with approx != exact
- err_sum  out  SUM_W  sum of |exact-approx|
- max_err  out  17  largest |exact-approx|
- max_err_a  out  OP_W  A at first occurrence of max_err
- max_err_b  out  OP_W  B at first occurrence of max_err

Behaviour:
- Reset: state IDLE. All outputs 0, all counters and stats cleared, operand registers 0.
- FSM:
  - IDLE: accepted start -> RUN. Latches conf_mask, clears stats, loads A=-128, B=-128.
  - RUN: drives the operand registers through the sweep. B is the inner loop from -128 to 127; A is the outer loop from -128 to 127. That is 65536 pairs, including 127.
  - RUN -> DRAIN: when pair (127,127) is accepted into the result stage.
  - DRAIN: waits for the last beat to be accepted -> DONE.
  - DONE: start -> RUN, with the same actions as from IDLE.
- Start handling: start in RUN/DRAIN is ignored. conf_mask changes after start have no effect.
- Pipeline, two stages:
  - Stage 1: registered A/B and latched mask drive the combinational signed_int_mul.
  - Stage 2: registers A, B, exact and R into res_* and sets res_valid.
- Stall: when res_valid && !res_ready, both stages hold and the operand counter does not advance. Stats update exactly once per beat, on the res_valid && res_ready handshake.
- Stats update on each handshake, with d = |exact - approx| computed at 17 bits, sign-extended:
  - err_count += (d != 0).
  - err_sum += d.
  - If d > max_err (strictly greater), update max_err, max_err_a and max_err_b. Ties keep the earliest pair.
- Exact product range: -16256..16384; always fits 16-bit signed.
- Stats outputs are live during the sweep and final once done=1.
- Latency with res_ready held at 1:
  - Start seen at edge 0.
  - First beat valid after edge 2 (a=-128, b=-128).
  - Last beat after edge 65537.
  - done=1 after edge 65538.
- Counter wrap: the 8-bit counters are never allowed to wrap past (127,127). The sweep terminates exactly there.
- rst mid-sweep: immediate return to IDLE with everything cleared. No beat is emitted in the cycle after rst.
- start and rst asserted together: rst wins.

Test Plan:
- rst, then start with conf_mask=6'b000001 and res_ready=1 -> beat 0 is a=-128, b=-128, res_exact=16384. Beat 65535 is a=127, b=127, res_exact=16129. Exactly 65536 beats. done=1 at cycle 65538 after start.
- Golden compare: bench computes err_count, err_sum, max_err and argmax from its own signed_int_mul model over the same sweep. Run for conf_mask 6'b000001 and 6'b111111 -> DUT totals match exactly. Zero-product pairs count as errors only when R != 0.
- Backpressure: res_ready toggled randomly at 50%, with 200 consecutive low cycles mid-sweep -> beat sequence identical to the ready=1 run, no drops or duplicates, final stats identical.
- Change conf_mask and pulse start during RUN -> ignored. Stats match the originally latched mask.
- rst asserted at beat 30000 -> next cycle: res_valid=0, busy=0, all stats 0. A new start restarts at (-128,-128).
- Restart from DONE with a different mask -> stats cleared at start. New totals match the golden results for the new mask.
